// File: rtl/rfblackwidow_ptg_writer_pkg.sv
// Shared types for the PTG writer: HPTE layout, FSM states, completion status.
package rfblackwidow_ptg_writer_pkg;

    localparam int unsigned PTGW_AWID        = 32;
    localparam int unsigned PTGW_PTE_PER_PTG = 8;

    // 128-bit hashed page table entry.
    typedef struct packed {
        logic        v;        // [127]     valid
        logic        g;        // [126]     global (ignores asid)
        logic        a;        // [125]     accessed (clock reference bit)
        logic        m;        // [124]     modified
        logic [3:0]  rsv;      // [123:120]
        logic [11:0] asid;     // [119:108]
        logic [15:0] vpnhi;    // [107:92]
        logic [31:0] vpn;      // [91:60]
        logic [59:0] ppn_attr; // [59:0]    ppn and access attributes
    } hpte_t;

    typedef enum logic [2:0] {
        PTGW_IDLE,
        PTGW_RD,
        PTGW_SCAN,
        PTGW_WR,
        PTGW_DONE
    } ptgw_state_e;

    typedef enum logic [1:0] {
        PTGW_INSERTED = 2'd0,
        PTGW_UPDATED  = 2'd1,
        PTGW_EVICTED  = 2'd2,
        PTGW_ERROR    = 2'd3
    } ptgw_status_e;

endpackage

// File: rtl/rfblackwidow_ptg_slot_sel.sv
// Combinational slot selector for a PTG insert.
//   entries : the 8 HPTEs read from the group
//   req     : HPTE being inserted
//   ptr     : clock pointer (eviction scan start)
//   slot    : chosen slot index
//   kind    : UPDATED (tag match), INSERTED (free slot) or EVICTED
// Priority: lowest matching valid entry, else lowest invalid entry, else the
// first a=0 entry scanning circularly from ptr, else the ptr slot itself.
module rfblackwidow_ptg_slot_sel
    import rfblackwidow_ptg_writer_pkg::*;
#(
    parameter int unsigned PTE_PER_PTG = PTGW_PTE_PER_PTG
) (
    input  hpte_t        entries [PTE_PER_PTG],
    input  hpte_t        req,
    input  logic [2:0]   ptr,
    output logic [2:0]   slot,
    output ptgw_status_e kind
);

    logic       match_hit;
    logic       free_hit;
    logic       old_hit;
    logic [2:0] match_idx;
    logic [2:0] free_idx;
    logic [2:0] old_idx;
    logic [2:0] scan_idx;
    logic       unused_fields;

    always_comb begin
        match_hit = 1'b0;
        free_hit  = 1'b0;
        old_hit   = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        old_idx   = ptr;
        scan_idx  = '0;

        for (int unsigned i = 0; i < PTE_PER_PTG; i++) begin
            if (!match_hit && entries[i].v &&
                entries[i].vpn == req.vpn && entries[i].vpnhi == req.vpnhi &&
                (entries[i].asid == req.asid || entries[i].g || req.g)) begin
                match_hit = 1'b1;
                match_idx = 3'(i);
            end
            if (!free_hit && !entries[i].v) begin
                free_hit = 1'b1;
                free_idx = 3'(i);
            end
        end

        // Clock sweep: start at ptr and wrap through the group once.
        for (int unsigned i = 0; i < PTE_PER_PTG; i++) begin
            scan_idx = ptr + 3'(i);
            if (!old_hit && !entries[scan_idx].a) begin
                old_hit = 1'b1;
                old_idx = scan_idx;
            end
        end

        if (match_hit) begin
            slot = match_idx;
            kind = PTGW_UPDATED;
        end else if (free_hit) begin
            slot = free_idx;
            kind = PTGW_INSERTED;
        end else begin
            slot = old_hit ? old_idx : ptr;
            kind = PTGW_EVICTED;
        end
    end

    // Payload fields do not take part in selection.
    always_comb begin
        unused_fields = ^req;
        for (int unsigned i = 0; i < PTE_PER_PTG; i++) begin
            unused_fields = unused_fields ^ (^entries[i]);
        end
    end

endmodule

// File: rtl/rfblackwidow_ptg_writer.sv
// Hash page table insert/update engine.
// Reads the 8-entry PTG at ptg_adr_i over a 128-bit bus, picks a slot
// (match / free / clock victim), writes pte_i there and reports the outcome.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   ins_req_i / ins_rdy_o  : insert request handshake
//   ptg_adr_i, pte_i       : group base (bits [6:0] ignored) and HPTE to insert
//   done_o                 : one-cycle completion pulse
//   status_o/slot_o/evicted_o : outcome, valid with done_o
//   cyc_o/stb_o/we_o/adr_o/dat_o/dat_i/ack_i/err_i : memory bus master
module rfblackwidow_ptg_writer
    import rfblackwidow_ptg_writer_pkg::*;
#(
    parameter int unsigned AWID        = PTGW_AWID,
    parameter int unsigned PTE_PER_PTG = PTGW_PTE_PER_PTG
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ins_req_i,
    output logic            ins_rdy_o,
    input  logic [AWID-1:0] ptg_adr_i,
    input  logic [127:0]    pte_i,
    output logic            done_o,
    output logic [1:0]      status_o,
    output logic [2:0]      slot_o,
    output logic [127:0]    evicted_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [AWID-1:0] adr_o,
    output logic [127:0]    dat_o,
    input  logic [127:0]    dat_i,
    input  logic            ack_i,
    input  logic            err_i
);

    ptgw_state_e  state, state_n;

    logic [AWID-8:0] base;
    hpte_t           pte_q;
    hpte_t           entries [PTE_PER_PTG];
    logic [2:0]      beat;
    logic            gap;
    logic [2:0]      clk_ptr;
    ptgw_status_e    status_q;
    logic [2:0]      slot_q;
    hpte_t           evicted_q;

    logic [2:0]      sel_slot;
    ptgw_status_e    sel_kind;
    logic            unused_adr_bits;

    assign unused_adr_bits = ^ptg_adr_i[6:0];

    rfblackwidow_ptg_slot_sel #(
        .PTE_PER_PTG(PTE_PER_PTG)
    ) u_slot_sel (
        .entries(entries),
        .req    (pte_q),
        .ptr    (clk_ptr),
        .slot   (sel_slot),
        .kind   (sel_kind)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= PTGW_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Bus outputs decode straight from state so that reset removes cyc/stb
    // immediately, without waiting for a clock edge.
    always_comb begin
        state_n   = state;
        ins_rdy_o = 1'b0;
        done_o    = 1'b0;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        we_o      = 1'b0;
        adr_o     = '0;
        dat_o     = '0;

        unique case (state)
            PTGW_IDLE: begin
                ins_rdy_o = 1'b1;
                if (ins_req_i) begin
                    state_n = PTGW_RD;
                end
            end
            PTGW_RD: begin
                // Each beat is a strobe cycle followed by a gap cycle with
                // stb low; cyc is released during the gap after the last beat.
                cyc_o = !(gap && beat == 3'd7);
                stb_o = !gap;
                adr_o = {base, beat, 4'b0000};
                if (!gap) begin
                    if (err_i) begin
                        state_n = PTGW_DONE;
                    end
                end else if (beat == 3'd7) begin
                    state_n = PTGW_SCAN;
                end
            end
            PTGW_SCAN: begin
                state_n = PTGW_WR;
            end
            PTGW_WR: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                adr_o = {base, slot_q, 4'b0000};
                dat_o = pte_q;
                if (ack_i || err_i) begin
                    state_n = PTGW_DONE;
                end
            end
            PTGW_DONE: begin
                done_o  = 1'b1;
                state_n = PTGW_IDLE;
            end
            default: begin
                state_n = PTGW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base      <= '0;
            pte_q     <= '0;
            beat      <= '0;
            gap       <= 1'b0;
            clk_ptr   <= '0;
            status_q  <= PTGW_INSERTED;
            slot_q    <= '0;
            evicted_q <= '0;
            for (int unsigned i = 0; i < PTE_PER_PTG; i++) begin
                entries[i] <= '0;
            end
        end else begin
            unique case (state)
                PTGW_IDLE: begin
                    if (ins_req_i) begin
                        base  <= ptg_adr_i[AWID-1:7];
                        pte_q <= hpte_t'(pte_i);
                        beat  <= '0;
                        gap   <= 1'b0;
                    end
                end
                PTGW_RD: begin
                    if (!gap) begin
                        if (err_i) begin
                            status_q  <= PTGW_ERROR;
                            slot_q    <= '0;
                            evicted_q <= '0;
                        end else if (ack_i) begin
                            entries[beat] <= hpte_t'(dat_i);
                            gap           <= 1'b1;
                        end
                    end else begin
                        gap <= 1'b0;
                        if (beat != 3'd7) begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                PTGW_SCAN: begin
                    slot_q   <= sel_slot;
                    status_q <= sel_kind;
                    if (sel_kind == PTGW_EVICTED) begin
                        evicted_q <= entries[sel_slot];
                        clk_ptr   <= sel_slot + 3'd1;
                    end else begin
                        evicted_q <= '0;
                    end
                end
                PTGW_WR: begin
                    if (err_i) begin
                        status_q <= PTGW_ERROR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign status_o  = status_q;
    assign slot_o    = slot_q;
    assign evicted_o = evicted_q;

endmodule

// File: tb/tb_rfblackwidow_ptg_writer.sv
module tb_rfblackwidow_ptg_writer;
    import rfblackwidow_ptg_writer_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         ins_req;
    logic         ins_rdy;
    logic [31:0]  ptg_adr;
    logic [127:0] pte;
    logic         done;
    logic [1:0]   status;
    logic [2:0]   slot;
    logic [127:0] evicted;
    logic         cyc, stb, we;
    logic [31:0]  adr;
    logic [127:0] wdat;
    logic [127:0] rdat;
    logic         ack, err;

    rfblackwidow_ptg_writer #(
        .AWID(32),
        .PTE_PER_PTG(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ins_req_i(ins_req), .ins_rdy_o(ins_rdy),
        .ptg_adr_i(ptg_adr), .pte_i(pte),
        .done_o(done), .status_o(status), .slot_o(slot), .evicted_o(evicted),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(wdat),
        .dat_i(rdat), .ack_i(ack), .err_i(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned cyc_cnt    = 0;
    int unsigned req_cycle  = 0;
    logic [31:0] cur_base   = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Bus slave model: zero-wait ack, optional error on one read beat or on the write.
    hpte_t       mem [8];
    logic        err_rd_en = 1'b0;
    logic [2:0]  err_beat  = '0;
    logic        err_wr_en = 1'b0;

    always_comb begin
        ack  = 1'b0;
        err  = 1'b0;
        rdat = '0;
        if (cyc && stb) begin
            if (!we) begin
                if (err_rd_en && adr[6:4] == err_beat) begin
                    err = 1'b1;
                end else begin
                    ack  = 1'b1;
                    rdat = mem[adr[6:4]];
                end
            end else if (err_wr_en) begin
                err = 1'b1;
            end else begin
                ack = 1'b1;
            end
        end
    end

    typedef struct {
        logic [1:0]  st;
        logic [2:0]  sl;
        hpte_t       ev;
        logic [31:0] base;
        hpte_t       dat;
        int unsigned nrd;
        int unsigned nwr;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: bus beats and completion, sampled on the falling edge.
    int unsigned rd_cnt = 0;
    int unsigned wr_cnt = 0;
    logic [31:0] wr_adr = '0;
    logic [127:0] wr_dat = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (cyc && stb && !we && ack) begin
                chk("rd_adr", adr, cur_base + 32'(rd_cnt) * 32'd16);
                rd_cnt++;
            end
            if (cyc && stb && we && (ack || err)) begin
                wr_cnt++;
                wr_adr = adr;
                wr_dat = wdat;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("status", status, e.st);
                    chk("slot", slot, e.sl);
                    if (e.st == PTGW_EVICTED) chk("evicted", evicted, e.ev);
                    chk("rd_beats", rd_cnt, e.nrd);
                    chk("wr_beats", wr_cnt, e.nwr);
                    if (e.nwr != 0) begin
                        chk("wr_adr", wr_adr, {e.base[31:7], e.sl, 4'h0});
                        chk("wr_dat", wr_dat, e.dat);
                    end
                    chk("latency", cyc_cnt - req_cycle, e.lat);
                    chk("cyc_at_done", {cyc, stb, we}, 3'b000);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    function automatic hpte_t mk(input logic v, input logic g, input logic a,
                                 input logic [11:0] asid, input logic [31:0] vpn,
                                 input logic [15:0] vpnhi, input logic [59:0] ppn);
        hpte_t h;
        h = '0;
        h.v = v; h.g = g; h.a = a;
        h.asid = asid; h.vpn = vpn; h.vpnhi = vpnhi; h.ppn_attr = ppn;
        return h;
    endfunction

    localparam logic [11:0] RASID  = 12'h05A;
    localparam logic [31:0] RVPN   = 32'h0001_2345;
    localparam logic [15:0] RVPNHI = 16'h0007;

    hpte_t req_pte;

    task automatic fill_invalid();
        for (int i = 0; i < 8; i++) mem[i] = mk(1'b0, 1'b0, 1'b1, RASID, RVPN, RVPNHI, 60'(i));
    endtask

    task automatic fill_other(input logic a);
        for (int i = 0; i < 8; i++)
            mem[i] = mk(1'b1, 1'b0, a, 12'h111, 32'h7000_0000 + 32'(i), RVPNHI, 60'h100 + 60'(i));
    endtask

    task automatic run(input logic [31:0] base, input hpte_t r, input logic [1:0] st,
                       input logic [2:0] sl, input hpte_t ev, input int unsigned nrd,
                       input int unsigned nwr, input int unsigned lat);
        exp_t e;
        int unsigned n;
        e.st = st; e.sl = sl; e.ev = ev; e.base = base; e.dat = r;
        e.nrd = nrd; e.nwr = nwr; e.lat = lat;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ins_rdy && n < 50);
        if (!ins_rdy) chk("rdy_timeout", 1'b0, 1'b1);
        cur_base  = {base[31:7], 7'h0};
        ptg_adr   = base;
        pte       = r;
        ins_req   = 1'b1;
        req_cycle = cyc_cnt;
        @(negedge clk);
        ins_req = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        ins_req = 1'b0;
        ptg_adr = '0;
        pte     = '0;
        req_pte = mk(1'b1, 1'b0, 1'b1, RASID, RVPN, RVPNHI, 60'hABC_DEF0);
        fill_invalid();
        repeat (3) @(negedge clk);
        chk("rst_cyc_stb_we", {cyc, stb, we}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", ins_rdy, 1'b1);
        chk("rst_done_status_slot", {done, status, slot}, 6'd0);
        chk("rst_evicted", evicted, 128'd0);
        chk("rst_adr_dat", {adr, wdat}, 160'd0);

        // Empty group: insert at slot 0, 19-cycle latency.
        fill_invalid();
        run(32'h1000_0080, req_pte, PTGW_INSERTED, 3'd0, '0, 8, 1, 19);

        // Slot 5 matches; slot 1 differs only in asid; 6,7 free.
        fill_other(1'b1);
        mem[1] = mk(1'b1, 1'b0, 1'b1, 12'h0A5, RVPN, RVPNHI, 60'h55);
        mem[5] = mk(1'b1, 1'b0, 1'b1, RASID, RVPN, RVPNHI, 60'h77);
        mem[6] = mk(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 16'h0, 60'h0);
        mem[7] = mk(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 16'h0, 60'h0);
        run(32'h1000_0080, req_pte, PTGW_UPDATED, 3'd5, '0, 8, 1, 19);

        // Full group, all referenced: victims walk 0..7, pointer wraps to 0.
        fill_other(1'b1);
        for (int i = 0; i < 8; i++)
            run(32'h4000_0000, req_pte, PTGW_EVICTED, 3'(i), mem[i], 8, 1, 19);

        // Advance the pointer to 6.
        for (int i = 0; i < 6; i++)
            run(32'h4000_0000, req_pte, PTGW_EVICTED, 3'(i), mem[i], 8, 1, 19);

        // Only slot 3 unreferenced, pointer 6 -> slot 3 (pointer becomes 4).
        fill_other(1'b1);
        mem[3].a = 1'b0;
        run(32'h4000_0000, req_pte, PTGW_EVICTED, 3'd3, mem[3], 8, 1, 19);
        fill_other(1'b1);
        run(32'h4000_0000, req_pte, PTGW_EVICTED, 3'd4, mem[4], 8, 1, 19);
        run(32'h4000_0000, req_pte, PTGW_EVICTED, 3'd5, mem[5], 8, 1, 19);

        // Slots 3 and 7 unreferenced, pointer 6 -> slot 7 (pointer wraps to 0).
        mem[3].a = 1'b0;
        mem[7].a = 1'b0;
        run(32'h4000_0000, req_pte, PTGW_EVICTED, 3'd7, mem[7], 8, 1, 19);

        // Global entry with a different asid matches; low address bits ignored.
        fill_invalid();
        mem[0] = mk(1'b1, 1'b0, 1'b1, RASID, 32'h0BAD_0000, RVPNHI, 60'h1);
        mem[1] = mk(1'b1, 1'b0, 1'b1, RASID, 32'h0BAD_0001, RVPNHI, 60'h2);
        mem[2] = mk(1'b1, 1'b1, 1'b1, 12'h3C3, RVPN, RVPNHI, 60'h3);
        mem[3] = mk(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 16'h0, 60'h0);
        run(32'h2000_017F, req_pte, PTGW_UPDATED, 3'd2, '0, 8, 1, 19);

        // Global request matches a non-global entry with a different asid.
        fill_other(1'b1);
        mem[4] = mk(1'b1, 1'b0, 1'b1, 12'h3C3, RVPN, RVPNHI, 60'h4);
        mem[5] = mk(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 16'h0, 60'h0);
        run(32'h2000_0100, mk(1'b1, 1'b1, 1'b1, RASID, RVPN, RVPNHI, 60'h9), PTGW_UPDATED, 3'd4, '0, 8, 1, 19);

        // Bus error on read beat 4: no write, error after beats 0-3.
        fill_invalid();
        err_rd_en = 1'b1;
        err_beat  = 3'd4;
        run(32'h5000_0000, req_pte, PTGW_ERROR, 3'd0, '0, 4, 0, 10);
        err_rd_en = 1'b0;

        // Bus error on the write: attempted slot still reported.
        fill_invalid();
        mem[0] = mk(1'b1, 1'b0, 1'b1, 12'h111, 32'h7000_0000, RVPNHI, 60'h1);
        mem[1] = mk(1'b1, 1'b0, 1'b1, 12'h111, 32'h7000_0001, RVPNHI, 60'h2);
        err_wr_en = 1'b1;
        run(32'h5000_0000, req_pte, PTGW_ERROR, 3'd2, '0, 8, 1, 19);
        err_wr_en = 1'b0;

        // Pointer unchanged by error cases: still 0, then move it to 2.
        fill_other(1'b1);
        run(32'h6000_0000, req_pte, PTGW_EVICTED, 3'd0, mem[0], 8, 1, 19);
        run(32'h6000_0000, req_pte, PTGW_EVICTED, 3'd1, mem[1], 8, 1, 19);

        // Reset during read beat 3 drops cyc/stb without a clock edge.
        fill_invalid();
        @(negedge clk);
        cur_base = 32'h3000_0000;
        ptg_adr  = 32'h3000_0000;
        pte      = req_pte;
        ins_req  = 1'b1;
        @(negedge clk);
        ins_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("beat3_stb_adr", {stb, adr}, {1'b1, 32'h3000_0030});
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc_stb", {cyc, stb}, 2'b00);
        chk("async_rst_rdy", ins_rdy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // After reset the pointer is back at 0.
        fill_other(1'b1);
        run(32'h3000_0000, req_pte, PTGW_EVICTED, 3'd0, mem[0], 8, 1, 19);

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rfblackwidow_ptg_writer.md
Name: rfblackwidow_ptg_writer

Overview:
Hash-page-table insert/update engine; the writer side of the PTG (page table group) lookups done by the MMU table walker.
- Takes an HPTE from the miss/fault handler and reads the target 8-entry PTG over the 128-bit memory bus.
- Chooses a slot: matching entry, else first invalid entry, else clock victim.
- Writes the HPTE back and reports the slot and any evicted entry for TLB shootdown.

Parameters:
AWID, 32, physical address width (matches the Address typedef).
PTE_PER_PTG, 8, HPTEs per group; fixed at 8 (3-bit slot index).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
ins_req_i  in  1  insert request; sampled when ins_rdy_o=1
ins_rdy_o  out  1  idle and able to accept a request
ptg_adr_i  in  AWID  PTG base; bits [6:0] ignored (128-byte group)
pte_i  in  128  HPTE to insert
done_o  out  1  one-cycle completion pulse
status_o  out  2  0 INSERTED, 1 UPDATED, 2 EVICTED, 3 ERROR; valid with done_o
slot_o  out  3  slot written; valid with done_o
evicted_o  out  128  displaced HPTE; valid with done_o when status=EVICTED
cyc_o  out  1  bus cycle
stb_o  out  1  strobe
we_o  out  1  write enable
adr_o  out  AWID  beat address
dat_o  out  128  write data
dat_i  in  128  read data
ack_i  in  1  beat acknowledge
err_i  in  1  bus error

Behaviour:
- Reset values: ins_rdy_o=1. All other outputs 0, including cyc/stb/we, done, status, slot, evicted, adr, dat_o. Clock pointer = 0.
- Reset is effective immediately at any state, including mid-bus-cycle: cyc_o/stb_o drop asynchronously and the request is lost.
- FSM states: IDLE, RD, SCAN, WR, DONE.
- IDLE:
  - When ins_req_i=1, latch ptg_adr_i and pte_i, set beat k=0, deassert ins_rdy_o, go to RD.
- RD:
  - Drive cyc=stb=1, we=0, adr_o = {base[AWID-1:7], k[2:0], 4'b0}.
  - On ack_i: capture dat_i into entry[k] and drop stb for one cycle; cyc stays high across beats. If k=7, drop cyc and go to SCAN; else k+1.
  - err_i takes priority over a simultaneous ack_i: drop cyc/stb, status=ERROR, slot=0, go to DONE. No write is performed.
- SCAN (one cycle): the slot selector picks the slot, priority highest first:
  1. Match: lowest index with v=1, vpn and vpnhi equal to the request, and (asid equal OR entry g=1 OR request g=1) -> UPDATED.
  2. Lowest index with v=0 -> INSERTED.
  3. First slot with a=0, scanning circularly from the clock pointer -> EVICTED.
  4. All a=1: the clock-pointer slot -> EVICTED.
  - On EVICTED: evicted_o = old entry, and the clock pointer becomes slot+1 mod 8 (wraps 7->0). The pointer is unchanged for UPDATED/INSERTED.
- WR:
  - Drive cyc=stb=we=1, adr_o = {base[AWID-1:7], slot, 4'b0}, dat_o = latched pte_i.
  - On ack_i: drop cyc/stb/we, go to DONE.
  - On err_i: status=ERROR, go to DONE; slot_o still reports the attempted slot.
- DONE: done_o=1 for one cycle, status/slot/evicted held stable; then IDLE with ins_rdy_o=1.
- ins_req_i while busy is ignored; the requester holds it until ins_rdy_o.
- Latency with zero-wait ack: 8 read beats (2 cycles each) + SCAN + WR + DONE. Request to done_o = 19 cycles minimum.
- There is no bus timeout; a hung bus is resolved by reset.

Decomposition:
- Add to rfBlackWidowMmuPkg:
  - state parameters PTGW_IDLE, PTGW_RD, PTGW_SCAN, PTGW_WR, PTGW_DONE;
  - status constants PTGW_INSERTED, PTGW_UPDATED, PTGW_EVICTED, PTGW_ERROR.
- Reuse the existing HPTE struct and `PtePerPtg.
- One combinational sub-module, rfblackwidow_ptg_slot_sel.
  - Inputs: PTG entries, request HPTE, clock pointer.
  - Outputs: slot, kind.
  - Separate so it can be unit-checked exhaustively.

Test Plan:
- Base 0x1000_0080, all 8 entries v=0 -> 8 reads at 0x1000_0080..0x1000_00F0. One write at 0x1000_0080. status=INSERTED, slot=0, done 19 cycles after the request with zero-wait ack.
- Slot 5 has v=1 and the same asid/vpn/vpnhi, slots 0-4 valid but different -> write at base+0x50, status=UPDATED, clock pointer unchanged.
- All valid, no match, all a=1, pointer=0 -> slot 0 EVICTED with evicted_o = old slot 0. Repeat the request -> slot 1, pointer=2. Repeat with pointer=7 -> slot 7, pointer wraps to 0.
- All valid, only slot 3 a=0, pointer=6 -> slot 3 EVICTED. Repeat with slots 3 and 7 a=0, pointer=6 -> slot 7.
- Global match: entry 2 g=1 with a different asid, same vpn -> UPDATED slot 2. err_i on read beat 4 -> no write beat, status=ERROR, cyc_o=0 next cycle.
- Assert rst_ni low during read beat 3 -> cyc_o/stb_o go 0 without waiting for a clock edge. After release, ins_rdy_o=1 and a new request completes normally.
